rf_cmd_ctrl: RTL and testbench
==============================

Name: rf_cmd_ctrl

Overview:
Command front-end that sits directly upstream of the register file. It consumes the byte stream from the UART receiver and decodes write frames (CMD, ADDR, DATA) and read frames (CMD, ADDR). It drives the register file's read/write port, captures the returned read data, and hands that data to the UART transmitter over a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and register data
ADDR_WIDTH, 4, register file address width
WR_CMD, 8'hAA, opcode for the write frame
RD_CMD, 8'hBB, opcode for the read frame
RD_TIMEOUT, 4, maximum number of cycles to wait for i_RdData_Valid after o_RdEn

Ports:
i_CLK  in  1  system clock, rising edge
i_RST  in  1  synchronous, active-high reset
i_RX_Data  in  DATA_WIDTH  received byte
i_RX_Valid  in  1  one-cycle strobe, i_RX_Data valid
i_RdData  in  DATA_WIDTH  register file read data
i_RdData_Valid  in  1  register file read data valid
i_TX_Ready  in  1  transmitter can accept a byte
o_WrEn  out  1  register file write enable
o_RdEn  out  1  register file read enable
o_Address  out  ADDR_WIDTH  register file address
o_WrData  out  DATA_WIDTH  register file write data
o_TX_Data  out  DATA_WIDTH  byte to transmitter
o_TX_Valid  out  1  o_TX_Data valid
o_Busy  out  1  frame in progress (state != IDLE)
o_Err  out  1  one-cycle error pulse

Behaviour:
- Clocking and reset: one clock, i_CLK. i_RST is synchronous and active-high.
- While i_RST is high at a rising edge, all outputs are forced to 0 and the FSM goes to IDLE. This also applies mid-frame: any partial frame is discarded and the timeout counter is cleared.
- All outputs are registered.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on i_RX_Valid:
  - byte == WR_CMD -> WR_ADDR.
  - byte == RD_CMD -> RD_ADDR.
  - any other byte -> o_Err pulses for 1 cycle; stay in IDLE.
- WR_ADDR / RD_ADDR, on i_RX_Valid:
  - If byte[DATA_WIDTH-1:ADDR_WIDTH] != 0: o_Err pulses; go to IDLE; no register file access.
  - Otherwise latch byte[ADDR_WIDTH-1:0] as the address. WR_ADDR -> WR_DATA. RD_ADDR -> RD_WAIT.
- WR_DATA, on i_RX_Valid:
  - Latch the byte as write data.
  - In the next cycle, o_WrEn = 1 for exactly 1 cycle, with o_Address/o_WrData stable; then IDLE.
  - Write latency: DATA byte accepted at edge N -> o_WrEn high between edges N and N+1.
- Read issue: on the address-accepting edge N, o_RdEn = 1 for exactly 1 cycle (N to N+1) with o_Address stable.
- RD_WAIT:
  - A counter starts at 0 on the cycle after o_RdEn and increments each cycle.
  - If i_RdData_Valid = 1: capture i_RdData into the TX holding register and go to TX_SEND.
  - Else if the counter == RD_TIMEOUT-1: o_Err pulses; go to IDLE.
  - i_RdData_Valid outside RD_WAIT is ignored.
- TX_SEND:
  - o_TX_Valid = 1 and o_TX_Data holds the captured byte. Both stay stable until a rising edge where i_TX_Ready = 1.
  - At that edge o_TX_Valid drops to 0 next cycle and the FSM goes to IDLE.
  - There is no timeout in TX_SEND.
- Bytes arriving in RD_WAIT or TX_SEND are dropped with an o_Err pulse. The FSM state is unchanged.
- o_Address and o_WrData default to 0 whenever their enable is low.
- o_Busy = 1 in every state except IDLE.
- Simultaneous events:
  - i_RX_Valid and i_RdData_Valid in the same RD_WAIT cycle: capture the read data AND pulse o_Err.
  - i_RST together with any other event: reset wins.
- Back-to-back frames are allowed: a new CMD byte is accepted in IDLE on the cycle immediately after a frame completes.

Test Plan:
1. Reset: assert i_RST for 2 edges mid-frame (after 0xAA, 0x07) -> all outputs 0, o_Busy = 0. Then the stream 0xAA, 0x07, 0x64 -> exactly one o_WrEn pulse with o_Address = 7, o_WrData = 100 (0x64); the partial frame never writes.
2. Write then read back: stream 0xAA, 0x0A, 0xC8, then 0xBB, 0x0A, with a real register file behind the block and i_TX_Ready = 1 -> o_WrEn (addr 10, data 200), then o_RdEn (addr 10), then o_TX_Valid with o_TX_Data = 0xC8 for 1 cycle.
3. TX backpressure: read of address 1 holding 0x05, with i_TX_Ready = 0 for 5 cycles -> o_TX_Valid high and o_TX_Data = 0x05 stable all 5 cycles; it clears 1 cycle after i_TX_Ready rises; o_Busy falls the same cycle.
4. Errors:
   - bad opcode 0x12 -> o_Err pulse, no enables asserted;
   - address byte 0x1F after 0xAA -> o_Err pulse, FSM back in IDLE, no o_WrEn.
5. Read timeout: 0xBB, 0x03 with i_RdData_Valid tied 0 -> o_Err pulses exactly RD_TIMEOUT (4) cycles after o_RdEn drops; o_TX_Valid never asserts; the next frame 0xAA, 0x02, 0x11 completes normally.
6. Dropped byte: byte 0x55 arrives while in TX_SEND -> o_Err pulse; the pending o_TX_Data is unchanged and is still delivered.

Source files
------------

// File: rtl/rf_cmd_ctrl_if.sv
// Bus bundle between the command front-end and its neighbours: UART RX bytes,
// register file read/write port and UART TX handshake.
interface rf_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] i_RX_Data;
  logic                  i_RX_Valid;
  logic [DATA_WIDTH-1:0] i_RdData;
  logic                  i_RdData_Valid;
  logic                  i_TX_Ready;
  logic                  o_WrEn;
  logic                  o_RdEn;
  logic [ADDR_WIDTH-1:0] o_Address;
  logic [DATA_WIDTH-1:0] o_WrData;
  logic [DATA_WIDTH-1:0] o_TX_Data;
  logic                  o_TX_Valid;
  logic                  o_Busy;
  logic                  o_Err;

  modport master (
    input  i_RX_Data, i_RX_Valid, i_RdData, i_RdData_Valid, i_TX_Ready,
    output o_WrEn, o_RdEn, o_Address, o_WrData, o_TX_Data, o_TX_Valid,
           o_Busy, o_Err
  );

  modport slave (
    output i_RX_Data, i_RX_Valid, i_RdData, i_RdData_Valid, i_TX_Ready,
    input  o_WrEn, o_RdEn, o_Address, o_WrData, o_TX_Data, o_TX_Valid,
           o_Busy, o_Err
  );
endinterface

// File: rtl/rf_cmd_ctrl.sv
// Decodes CMD/ADDR[/DATA] byte frames from the UART into register file
// accesses and forwards read results to the UART transmitter.
module rf_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int                    RD_TIMEOUT = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  rf_cmd_ctrl_if.master    bus
);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  addr_ok;

  assign addr_ok = (bus.i_RX_Data[DATA_WIDTH-1:ADDR_WIDTH] == '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    address_d  = '0;
    wr_data_d  = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_RX_Valid) begin
          if (bus.i_RX_Data == WR_CMD)      state_d = WR_ADDR;
          else if (bus.i_RX_Data == RD_CMD) state_d = RD_ADDR;
          else                              err_d   = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (bus.i_RX_Valid) begin
          if (!addr_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d = bus.i_RX_Data[ADDR_WIDTH-1:0];
            if (state_q == WR_ADDR) begin
              state_d = WR_DATA;
            end else begin
              // Read is issued on the same edge the address is accepted.
              rd_en_d   = 1'b1;
              address_d = bus.i_RX_Data[ADDR_WIDTH-1:0];
              cnt_d     = '0;
              state_d   = RD_WAIT;
            end
          end
        end
      end
      WR_DATA: begin
        if (bus.i_RX_Valid) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = bus.i_RX_Data;
          state_d   = IDLE;
        end
      end
      RD_WAIT: begin
        err_d = bus.i_RX_Valid;
        if (bus.i_RdData_Valid) begin
          tx_data_d  = bus.i_RdData;
          tx_valid_d = 1'b1;
          state_d    = TX_SEND;
        end else if (!rd_en_q) begin
          // Timeout counting starts on the cycle after the read strobe.
          if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TX_SEND: begin
        err_d = bus.i_RX_Valid;
        if (bus.i_TX_Ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      address_q  <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      address_q  <= address_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_WrEn     = wr_en_q;
  assign bus.o_RdEn     = rd_en_q;
  assign bus.o_Address  = address_q;
  assign bus.o_WrData   = wr_data_q;
  assign bus.o_TX_Data  = tx_data_q;
  assign bus.o_TX_Valid = tx_valid_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Err      = err_q;
endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed bench for rf_cmd_ctrl with a small synchronous register file model
// answering reads one cycle after o_RdEn.
module tb_rf_cmd_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rf_respond;

  always #5 clk = ~clk;

  rf_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rf_cmd_ctrl dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  logic [7:0] mem [16];

  always @(posedge clk) begin
    if (bus.o_WrEn) mem[bus.o_Address] <= bus.o_WrData;
    if (bus.o_RdEn && rf_respond) begin
      bus.i_RdData_Valid <= 1'b1;
      bus.i_RdData       <= mem[bus.o_Address];
    end else begin
      bus.i_RdData_Valid <= 1'b0;
      bus.i_RdData       <= 8'h00;
    end
  end

  int wr_cnt = 0;
  int rd_cnt = 0;
  int txv_cnt = 0;
  always @(negedge clk) begin
    if (bus.o_WrEn)     wr_cnt++;
    if (bus.o_RdEn)     rd_cnt++;
    if (bus.o_TX_Valid) txv_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_Data  = b;
    bus.i_RX_Valid = 1'b1;
    step();
    bus.i_RX_Valid = 1'b0;
    bus.i_RX_Data  = 8'h00;
  endtask

  int wr0, rd0, tx0;

  initial begin
    rst = 1'b1;
    rf_respond = 1'b1;
    bus.i_RX_Data  = 8'h00;
    bus.i_RX_Valid = 1'b0;
    bus.i_TX_Ready = 1'b1;
    step();
    step();
    check("rst_wren", bus.o_WrEn, 0);
    check("rst_rden", bus.o_RdEn, 0);
    check("rst_txv",  bus.o_TX_Valid, 0);
    check("rst_busy", bus.o_Busy, 0);
    check("rst_err",  bus.o_Err, 0);
    rst = 1'b0;

    // 1: reset mid-frame, then a clean write
    wr0 = wr_cnt;
    send_byte(8'hAA);
    check("t1_busy_cmd", bus.o_Busy, 1);
    send_byte(8'h07);
    check("t1_busy_addr", bus.o_Busy, 1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("t1_rst_busy", bus.o_Busy, 0);
    check("t1_rst_addr", bus.o_Address, 0);
    send_byte(8'h64);
    check("t1_stray_err", bus.o_Err, 1);
    check("t1_stray_wren", bus.o_WrEn, 0);
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h64);
    check("t1_wren", bus.o_WrEn, 1);
    check("t1_addr", bus.o_Address, 7);
    check("t1_wdata", bus.o_WrData, 8'h64);
    step();
    check("t1_wren_drop", bus.o_WrEn, 0);
    check("t1_addr_zero", bus.o_Address, 0);
    check("t1_wr_pulses", wr_cnt - wr0, 1);

    // 2: write then read back
    send_byte(8'hAA);
    send_byte(8'h0A);
    send_byte(8'hC8);
    check("t2_wren", bus.o_WrEn, 1);
    check("t2_addr", bus.o_Address, 10);
    check("t2_wdata", bus.o_WrData, 8'hC8);
    step();
    send_byte(8'hBB);
    send_byte(8'h0A);
    check("t2_rden", bus.o_RdEn, 1);
    check("t2_raddr", bus.o_Address, 10);
    check("t2_busy", bus.o_Busy, 1);
    step();
    check("t2_rden_drop", bus.o_RdEn, 0);
    check("t2_txv_early", bus.o_TX_Valid, 0);
    tx0 = txv_cnt;
    step();
    check("t2_txv", bus.o_TX_Valid, 1);
    check("t2_txdata", bus.o_TX_Data, 8'hC8);
    step();
    check("t2_txv_drop", bus.o_TX_Valid, 0);
    check("t2_busy_drop", bus.o_Busy, 0);
    check("t2_txv_cycles", txv_cnt - tx0, 1);

    // 3: TX backpressure
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h05);
    step();
    bus.i_TX_Ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h01);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      check($sformatf("t3_txv_hold%0d", i), bus.o_TX_Valid, 1);
      check($sformatf("t3_txd_hold%0d", i), bus.o_TX_Data, 8'h05);
    end
    bus.i_TX_Ready = 1'b1;
    step();
    check("t3_txv_drop", bus.o_TX_Valid, 0);
    check("t3_busy_drop", bus.o_Busy, 0);

    // 4: bad opcode and bad address
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_byte(8'h12);
    check("t4_op_err", bus.o_Err, 1);
    check("t4_op_busy", bus.o_Busy, 0);
    step();
    check("t4_op_err_drop", bus.o_Err, 0);
    send_byte(8'hAA);
    send_byte(8'h1F);
    check("t4_addr_err", bus.o_Err, 1);
    check("t4_addr_busy", bus.o_Busy, 0);
    step();
    check("t4_no_wr", wr_cnt - wr0, 0);
    check("t4_no_rd", rd_cnt - rd0, 0);

    // 5: read timeout, then a normal write
    rf_respond = 1'b0;
    tx0 = txv_cnt;
    send_byte(8'hBB);
    send_byte(8'h03);
    check("t5_rden", bus.o_RdEn, 1);
    step();
    check("t5_rden_drop", bus.o_RdEn, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("t5_no_err%0d", i), bus.o_Err, 0);
    end
    step();
    check("t5_timeout_err", bus.o_Err, 1);
    check("t5_busy_drop", bus.o_Busy, 0);
    step();
    check("t5_err_drop", bus.o_Err, 0);
    check("t5_no_txv", txv_cnt - tx0, 0);
    rf_respond = 1'b1;
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11);
    check("t5_wren", bus.o_WrEn, 1);
    check("t5_addr", bus.o_Address, 2);
    check("t5_wdata", bus.o_WrData, 8'h11);
    step();

    // 6: byte dropped while in TX_SEND
    bus.i_TX_Ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h02);
    step();
    step();
    check("t6_txv", bus.o_TX_Valid, 1);
    send_byte(8'h55);
    check("t6_err", bus.o_Err, 1);
    check("t6_txv_kept", bus.o_TX_Valid, 1);
    check("t6_txd_kept", bus.o_TX_Data, 8'h11);
    check("t6_busy", bus.o_Busy, 1);
    bus.i_TX_Ready = 1'b1;
    step();
    check("t6_txv_drop", bus.o_TX_Valid, 0);
    check("t6_err_drop", bus.o_Err, 0);

    // 7: RX byte and read data in the same RD_WAIT cycle
    send_byte(8'hBB);
    send_byte(8'h07);
    step();
    send_byte(8'h99);
    check("t7_err", bus.o_Err, 1);
    check("t7_txv", bus.o_TX_Valid, 1);
    check("t7_txd", bus.o_TX_Data, 8'h64);
    step();
    check("t7_txv_drop", bus.o_TX_Valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
